// File: rtl/synth_param_bank_if.sv
// Keyboard-side inputs and parameter-value outputs of the synth parameter bank.
// The bench or PS/2 front end is the master; the parameter bank is the slave.
interface synth_param_bank_if #(
    parameter int NUM_PARAMS = 8,
    parameter int VAL_W      = 7
);
    logic [255:0]                key_down;
    logic                        repeat_en;
    logic                        load_defaults;
    logic [NUM_PARAMS*VAL_W-1:0] values;
    logic [NUM_PARAMS-1:0]       changed;

    modport master (
        output key_down,
        output repeat_en,
        output load_defaults,
        input  values,
        input  changed
    );

    modport slave (
        input  key_down,
        input  repeat_en,
        input  load_defaults,
        output values,
        output changed
    );
endinterface

// File: rtl/synth_param_bank.sv
// Keyboard-driven parameter bank: each channel has an up/down key pair with
// typematic auto-repeat and per-channel step, bounds, init value and wrap/clamp mode.
module synth_param_bank #(
    parameter int                          NUM_PARAMS   = 8,
    parameter int                          VAL_W        = 7,
    parameter logic [NUM_PARAMS*8-1:0]     UP_CODES     = {NUM_PARAMS{8'h75}},
    parameter logic [NUM_PARAMS*8-1:0]     DN_CODES     = {NUM_PARAMS{8'h72}},
    parameter logic [NUM_PARAMS*VAL_W-1:0] STEP         = {NUM_PARAMS{VAL_W'(1)}},
    parameter logic [NUM_PARAMS*VAL_W-1:0] MIN_VAL      = '0,
    parameter logic [NUM_PARAMS*VAL_W-1:0] MAX_VAL      = '1,
    parameter logic [NUM_PARAMS*VAL_W-1:0] INIT_VAL     = '0,
    parameter logic [NUM_PARAMS-1:0]       WRAP_MASK    = '0,
    parameter int                          REPEAT_DELAY = 25_000_000,
    parameter int                          REPEAT_RATE  = 5_000_000
) (
    input  logic               clk,
    input  logic               reset,
    synth_param_bank_if.slave  bus
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    // Low for the first cycle after reset so keys already held at release never count as presses.
    logic armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_ch
        localparam logic [7:0]       UPC   = UP_CODES[8*i +: 8];
        localparam logic [7:0]       DNC   = DN_CODES[8*i +: 8];
        localparam logic [VAL_W-1:0] STP   = STEP[VAL_W*i +: VAL_W];
        localparam logic [VAL_W-1:0] MINV  = MIN_VAL[VAL_W*i +: VAL_W];
        localparam logic [VAL_W-1:0] MAXV  = MAX_VAL[VAL_W*i +: VAL_W];
        localparam logic [VAL_W-1:0] INITV = INIT_VAL[VAL_W*i +: VAL_W];
        localparam logic             WRAP  = WRAP_MASK[i];

        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_last;
        logic [VAL_W-1:0] val_q;
        logic             chg_q;
        logic             prev_up;
        logic             prev_dn;
        logic             dir_up_q;

        logic             up_lvl;
        logic             dn_lvl;
        logic             press;
        logic             held;
        logic             step_up;
        logic [VAL_W:0]   up_sum;
        logic [VAL_W:0]   dn_floor;
        logic [VAL_W-1:0] up_val;
        logic [VAL_W-1:0] dn_val;
        logic [VAL_W-1:0] step_val;

        assign up_lvl   = bus.key_down[UPC];
        assign dn_lvl   = bus.key_down[DNC];
        assign press    = armed & ((up_lvl & ~prev_up & ~dn_lvl) | (dn_lvl & ~prev_dn & ~up_lvl));
        assign held     = dir_up_q ? (up_lvl & ~dn_lvl) : (dn_lvl & ~up_lvl);
        assign step_up  = (state_q == IDLE) ? up_lvl : dir_up_q;
        assign cnt_last = (state_q == DELAY) ? DELAY_LAST : RATE_LAST;

        // One extra bit keeps v+STEP and MIN+STEP from overflowing before the bound test.
        always_comb begin
            up_sum   = {1'b0, val_q} + {1'b0, STP};
            dn_floor = {1'b0, MINV} + {1'b0, STP};
            up_val   = up_sum[VAL_W-1:0];
            dn_val   = val_q - STP;
            if (up_sum > {1'b0, MAXV}) begin
                up_val = WRAP ? MINV : MAXV;
            end
            if ({1'b0, val_q} < dn_floor) begin
                dn_val = WRAP ? MAXV : MINV;
            end
            step_val = step_up ? up_val : dn_val;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                val_q    <= INITV;
                chg_q    <= 1'b0;
                prev_up  <= 1'b0;
                prev_dn  <= 1'b0;
                dir_up_q <= 1'b0;
            end else begin
                prev_up <= up_lvl;
                prev_dn <= dn_lvl;
                chg_q   <= 1'b0;
                if (bus.load_defaults) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    val_q   <= INITV;
                    chg_q   <= (val_q != INITV);
                end else begin
                    case (state_q)
                        IDLE: begin
                            cnt_q <= '0;
                            if (press) begin
                                dir_up_q <= up_lvl;
                                state_q  <= DELAY;
                                val_q    <= step_val;
                                chg_q    <= (step_val != val_q);
                            end
                        end
                        DELAY, REPEAT: begin
                            if (!held) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else if (cnt_q == cnt_last) begin
                                cnt_q <= '0;
                                if (bus.repeat_en) begin
                                    state_q <= REPEAT;
                                    val_q   <= step_val;
                                    chg_q   <= (step_val != val_q);
                                end else begin
                                    state_q <= IDLE;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    endcase
                end
            end
        end

        assign bus.values[VAL_W*i +: VAL_W] = val_q;
        assign bus.changed[i]               = chg_q;
    end

endmodule
